// File: rtl/risc_pkg.sv
// Shared RISC definitions: opcodes, control-FSM state encodings, mux selects
// and the opcode-driven datapath select decode.
package risc_pkg;

  localparam int unsigned OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_LI  = 4'b1000;
  localparam logic [OPCODE_W-1:0] OP_LW  = 4'b1001;
  localparam logic [OPCODE_W-1:0] OP_SW  = 4'b1010;
  localparam logic [OPCODE_W-1:0] OP_BZ  = 4'b1011;
  localparam logic [OPCODE_W-1:0] OP_BNZ = 4'b1100;
  localparam logic [OPCODE_W-1:0] OP_JAL = 4'b1101;
  localparam logic [OPCODE_W-1:0] OP_J   = 4'b1110;
  localparam logic [OPCODE_W-1:0] OP_JR  = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_FETCH1 = 3'b001,
    ST_FETCH2 = 3'b010,
    ST_EXEC1  = 3'b011,
    ST_EXEC2  = 3'b100,
    ST_HALT   = 3'b101,
    ST_ERR    = 3'b110
  } state_t;

  localparam logic [1:0] DATA_SEL_0 = 2'b00;
  localparam logic [1:0] DATA_SEL_1 = 2'b01;
  localparam logic [1:0] DATA_SEL_2 = 2'b10;
  localparam logic [1:0] OPB_SEL_0  = 2'b00;
  localparam logic [1:0] OPB_SEL_1  = 2'b01;
  localparam logic [1:0] OPB_SEL_2  = 2'b10;
  localparam logic [1:0] OPB_SEL_3  = 2'b11;

  typedef struct packed {
    logic       pc_rst;
    logic       pc_wrt;
    logic       ir_wrt;
    logic       addr_sel;
    logic       rega_sel;
    logic       reg_wrt;
    logic       opa_sel;
    logic       re;
    logic       we;
    logic [1:0] data_sel;
    logic [1:0] opb_sel;
    logic [2:0] alu_sel;
  } ctrl_t;

  // Mux selects the opcode asks for from decode onward; strobes stay 0 here.
  function automatic ctrl_t base_sel(logic [OPCODE_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_LI: c.opb_sel = OPB_SEL_3;
      OP_LW, OP_SW: begin
        c.addr_sel = 1'b1;
        c.data_sel = DATA_SEL_1;
      end
      OP_BZ, OP_BNZ: begin
        c.rega_sel = 1'b1;
        c.opa_sel  = 1'b1;
        c.data_sel = DATA_SEL_2;
        c.opb_sel  = OPB_SEL_3;
      end
      OP_JAL: begin
        c.opa_sel  = 1'b1;
        c.data_sel = DATA_SEL_2;
        c.opb_sel  = OPB_SEL_3;
      end
      OP_J: begin
        c.opa_sel  = 1'b1;
        c.data_sel = DATA_SEL_1;
        c.opb_sel  = OPB_SEL_3;
      end
      OP_JR: begin
        c.data_sel = DATA_SEL_1;
        c.opb_sel  = OPB_SEL_1;
      end
      default: begin
        c.data_sel = DATA_SEL_1;
        c.alu_sel  = op[2:0];
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ctrl_unit_mc_if.sv
// Datapath-facing bundle of the multi-cycle control unit: IR/regfile/memory
// inputs plus every datapath mux select and write strobe.
interface ctrl_unit_mc_if #(
  parameter int unsigned DATA_W = 16
);
  logic [3:0]        opcode;
  logic [DATA_W-1:0] rega_data;
  logic              mem_rdy;
  logic              pc_rst;
  logic              pc_wrt;
  logic              ir_wrt;
  logic              addr_sel;
  logic              rega_sel;
  logic              reg_wrt;
  logic              opa_sel;
  logic              re;
  logic              we;
  logic [1:0]        data_sel;
  logic [1:0]        opb_sel;
  logic [2:0]        alu_sel;

  modport master (
    input  opcode, rega_data, mem_rdy,
    output pc_rst, pc_wrt, ir_wrt, addr_sel, rega_sel, reg_wrt, opa_sel,
           re, we, data_sel, opb_sel, alu_sel
  );

  modport slave (
    output opcode, rega_data, mem_rdy,
    input  pc_rst, pc_wrt, ir_wrt, addr_sel, rega_sel, reg_wrt, opa_sel,
           re, we, data_sel, opb_sel, alu_sel
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access and flags expiry
// on the cycle the count has reached TIMEOUT with the memory still not ready.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic waiting,
  input  logic mem_rdy,
  output logic expired
);
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                cnt <= '0;
    else if (clear)              cnt <= '0;
    else if (waiting && !mem_rdy) cnt <= cnt + CNT_W'(1);
  end

  // A ready memory on the expiry cycle still completes the access.
  assign expired = (TIMEOUT != 32'd0) && waiting && !mem_rdy &&
                   (cnt == CNT_W'(TIMEOUT));
endmodule

// File: rtl/ctrl_unit_mc.sv
// Multi-cycle control unit: FETCH1/FETCH2/EXEC1/EXEC2 sequencing with memory
// wait states, bus timeout, halt/resume and a retired-instruction counter.
module ctrl_unit_mc
  import risc_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  ctrl_unit_mc_if.master   dp,
  input  logic             halt_req,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired
);
  state_t state_q, state_d;
  ctrl_t  base, ctl;
  logic   mem_op, waiting, expired, zero, wait_clr;

  assign mem_op   = (dp.opcode == OP_LW) || (dp.opcode == OP_SW);
  assign waiting  = (state_q == ST_FETCH1) || ((state_q == ST_EXEC1) && mem_op);
  assign zero     = (dp.rega_data == DATA_W'(0));
  assign wait_clr = (state_d != state_q);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (wait_clr),
    .waiting (waiting),
    .mem_rdy (dp.mem_rdy),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH1;
      ST_FETCH1: begin
        if (dp.mem_rdy)   state_d = ST_FETCH2;
        else if (expired) state_d = ST_ERR;
      end
      ST_FETCH2: state_d = ST_EXEC1;
      ST_EXEC1: begin
        if (!mem_op || dp.mem_rdy) state_d = ST_EXEC2;
        else if (expired)          state_d = ST_ERR;
      end
      ST_EXEC2:  state_d = halt_req ? ST_HALT : ST_FETCH1;
      ST_HALT:   if (!halt_req) state_d = ST_FETCH1;
      ST_ERR:    state_d = ST_ERR;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath controls from current state and opcode.
  always_comb begin
    base = base_sel(dp.opcode);
    ctl  = '0;
    case (state_q)
      ST_IDLE: ctl.pc_rst = 1'b1;
      ST_FETCH1: begin
        ctl.re       = 1'b1;
        ctl.opa_sel  = 1'b1;
        ctl.data_sel = DATA_SEL_1;
        ctl.opb_sel  = OPB_SEL_2;
        ctl.ir_wrt   = dp.mem_rdy;
      end
      ST_FETCH2: begin
        ctl         = base;
        ctl.pc_wrt  = 1'b1;
        ctl.reg_wrt = (dp.opcode == OP_JAL);
      end
      ST_EXEC1, ST_EXEC2: begin
        ctl = base;
        if (dp.opcode >= OP_BZ) ctl.data_sel = DATA_SEL_1;
        if (state_q == ST_EXEC1) begin
          ctl.re = (dp.opcode == OP_LW);
          ctl.we = (dp.opcode == OP_SW);
        end else begin
          if (!dp.opcode[3]) begin
            ctl.reg_wrt  = 1'b1;
            ctl.data_sel = DATA_SEL_2;
          end
          case (dp.opcode)
            OP_LI, OP_LW:      ctl.reg_wrt = 1'b1;
            OP_BZ:             ctl.pc_wrt  = zero;
            OP_BNZ:            ctl.pc_wrt  = !zero;
            OP_JAL, OP_J, OP_JR: ctl.pc_wrt = 1'b1;
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                retired <= '0;
    else if (state_q == ST_EXEC2) retired <= retired + CNT_W'(1);
  end

  assign dp.pc_rst   = ctl.pc_rst;
  assign dp.pc_wrt   = ctl.pc_wrt;
  assign dp.ir_wrt   = ctl.ir_wrt;
  assign dp.addr_sel = ctl.addr_sel;
  assign dp.rega_sel = ctl.rega_sel;
  assign dp.reg_wrt  = ctl.reg_wrt;
  assign dp.opa_sel  = ctl.opa_sel;
  assign dp.re       = ctl.re;
  assign dp.we       = ctl.we;
  assign dp.data_sel = ctl.data_sel;
  assign dp.opb_sel  = ctl.opb_sel;
  assign dp.alu_sel  = ctl.alu_sel;

  assign state      = state_q;
  assign instr_done = (state_q == ST_EXEC2);
  assign halted     = (state_q == ST_HALT);
  assign bus_err    = (state_q == ST_ERR);
endmodule

// File: tb/tb_ctrl_unit_mc.sv
// Bench for ctrl_unit_mc: two instances (default parameters, and TIMEOUT=3 /
// CNT_W=2) share stimulus; directed scenarios plus a randomized model run.
module tb_ctrl_unit_mc;
  localparam int TO_A = 15;
  localparam int TO_B = 3;
  localparam int CW_A = 16;
  localparam int CW_B = 2;

  typedef struct packed {
    logic pc_rst, pc_wrt, ir_wrt, addr_sel, rega_sel, reg_wrt, opa_sel, re, we;
    logic [1:0] data_sel;
    logic [1:0] opb_sel;
    logic [2:0] alu_sel;
  } ctl_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  opcode = '0;
  logic [15:0] rega_data = '0;
  logic        mem_rdy = 1'b0;
  logic        halt_req = 1'b0;

  logic [2:0]      state_a, state_b;
  logic            done_a, done_b, halted_a, halted_b, err_a, err_b;
  logic [CW_A-1:0] retired_a;
  logic [CW_B-1:0] retired_b;
  ctl_t            ctl_a, ctl_b;

  int checks = 0;
  int errors = 0;
  int m_st[2], m_nr[2], m_ret[2];

  always #5 clk = ~clk;

  ctrl_unit_mc_if #(.DATA_W(16)) ifa ();
  ctrl_unit_mc_if #(.DATA_W(16)) ifb ();

  assign ifa.opcode = opcode;  assign ifa.rega_data = rega_data;  assign ifa.mem_rdy = mem_rdy;
  assign ifb.opcode = opcode;  assign ifb.rega_data = rega_data;  assign ifb.mem_rdy = mem_rdy;

  assign ctl_a = {ifa.pc_rst, ifa.pc_wrt, ifa.ir_wrt, ifa.addr_sel, ifa.rega_sel, ifa.reg_wrt,
                  ifa.opa_sel, ifa.re, ifa.we, ifa.data_sel, ifa.opb_sel, ifa.alu_sel};
  assign ctl_b = {ifb.pc_rst, ifb.pc_wrt, ifb.ir_wrt, ifb.addr_sel, ifb.rega_sel, ifb.reg_wrt,
                  ifb.opa_sel, ifb.re, ifb.we, ifb.data_sel, ifb.opb_sel, ifb.alu_sel};

  ctrl_unit_mc #(.DATA_W(16), .TIMEOUT(TO_A), .CNT_W(CW_A)) dut_a (
    .clk(clk), .reset_n(reset_n), .dp(ifa), .halt_req(halt_req), .state(state_a),
    .instr_done(done_a), .halted(halted_a), .bus_err(err_a), .retired(retired_a));

  ctrl_unit_mc #(.DATA_W(16), .TIMEOUT(TO_B), .CNT_W(CW_B)) dut_b (
    .clk(clk), .reset_n(reset_n), .dp(ifb), .halt_req(halt_req), .state(state_b),
    .instr_done(done_b), .halted(halted_b), .bus_err(err_b), .retired(retired_b));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; tick(); tick(); reset_n = 1'b1;
  endtask

  // Expected controls written from the per-state / per-opcode output rules.
  function automatic ctl_t exp_ctl(int ph, int op, bit z, bit mr);
    ctl_t c;
    c = '0;
    if (ph == 0) c.pc_rst = 1;
    if (ph == 1) begin
      c.re = 1; c.opa_sel = 1; c.data_sel = 2'b01; c.opb_sel = 2'b10; c.ir_wrt = mr;
    end
    if (ph >= 2 && ph <= 4) begin
      if (op < 8) begin c.data_sel = 2'b01; c.alu_sel = 3'(op % 8); end
      if (op == 8) c.opb_sel = 2'b11;
      if (op == 9 || op == 10) begin c.addr_sel = 1; c.data_sel = 2'b01; end
      if (op == 11 || op == 12) begin c.rega_sel = 1; c.opa_sel = 1; c.data_sel = 2'b10; c.opb_sel = 2'b11; end
      if (op == 13) begin c.opa_sel = 1; c.data_sel = 2'b10; c.opb_sel = 2'b11; end
      if (op == 14) begin c.opa_sel = 1; c.data_sel = 2'b01; c.opb_sel = 2'b11; end
      if (op == 15) begin c.data_sel = 2'b01; c.opb_sel = 2'b01; end
      if (ph == 2) begin c.pc_wrt = 1; c.reg_wrt = (op == 13); end
      else if (op >= 11) c.data_sel = 2'b01;
      if (ph == 3) begin c.re = (op == 9); c.we = (op == 10); end
      if (ph == 4) begin
        if (op < 8) begin c.reg_wrt = 1; c.data_sel = 2'b10; end
        if (op == 8 || op == 9) c.reg_wrt = 1;
        if (op == 11) c.pc_wrt = z;
        if (op == 12) c.pc_wrt = !z;
        if (op >= 13) c.pc_wrt = 1;
      end
    end
    return c;
  endfunction

  // Reference next-state, counted in consecutive not-ready cycles.
  task automatic model_step(input int k, input int to);
    int st, nxt;
    bit memop, wt;
    st = m_st[k];
    if (!reset_n) begin m_st[k] = 0; m_nr[k] = 0; m_ret[k] = 0; return; end
    memop = (opcode == 4'd9) || (opcode == 4'd10);
    wt = (st == 1) || (st == 3 && memop);
    if (st == 4) m_ret[k]++;
    if (wt && !mem_rdy) begin
      m_nr[k]++;
      nxt = (to != 0 && m_nr[k] > to) ? 6 : st;
    end else begin
      case (st)
        0: nxt = 1;  1: nxt = 2;  2: nxt = 3;  3: nxt = 4;
        4: nxt = halt_req ? 5 : 1;
        5: nxt = halt_req ? 5 : 1;
        6: nxt = 6;
        default: nxt = 0;
      endcase
    end
    if (nxt != st) m_nr[k] = 0;
    m_st[k] = nxt;
  endtask

  task automatic test_reset();
    ctl_t e;
    e = '0; e.pc_rst = 1;
    opcode = 4'hD; mem_rdy = 1; halt_req = 1; rega_data = '0; reset_n = 0;
    tick(); @(negedge clk);
    checks++; if (state_a !== 3'b000) begin errors++; $display("FAIL reset_state_a got %b exp 000", state_a); end
    checks++; if (state_b !== 3'b000) begin errors++; $display("FAIL reset_state_b got %b exp 000", state_b); end
    checks++; if (ctl_a !== e) begin errors++; $display("FAIL reset_ctl_a got %h exp %h", ctl_a, e); end
    checks++; if (ctl_b !== e) begin errors++; $display("FAIL reset_ctl_b got %h exp %h", ctl_b, e); end
    checks++; if ({done_a, halted_a, err_a, retired_a} !== '0) begin errors++; $display("FAIL reset_status_a got %b%b%b %0d exp 0", done_a, halted_a, err_a, retired_a); end
    checks++; if ({done_b, halted_b, err_b, retired_b} !== '0) begin errors++; $display("FAIL reset_status_b got %b%b%b %0d exp 0", done_b, halted_b, err_b, retired_b); end
    halt_req = 0;
  endtask

  task automatic test_alu();
    int exp_st[6] = '{0, 1, 2, 3, 4, 1};
    ctl_t e1, e2, e4;
    e1 = '0; e1.re = 1; e1.opa_sel = 1; e1.data_sel = 2'b01; e1.opb_sel = 2'b10; e1.ir_wrt = 1;
    e2 = '0; e2.pc_wrt = 1; e2.data_sel = 2'b01; e2.alu_sel = 3'b011;
    e4 = '0; e4.reg_wrt = 1; e4.data_sel = 2'b10; e4.alu_sel = 3'b011;
    apply_reset();
    opcode = 4'b0011; mem_rdy = 1; halt_req = 0; rega_data = 16'h1234;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if (state_a !== 3'(exp_st[c])) begin errors++; $display("FAIL alu_state_a c%0d got %0d exp %0d", c, state_a, exp_st[c]); end
      checks++; if (state_b !== 3'(exp_st[c])) begin errors++; $display("FAIL alu_state_b c%0d got %0d exp %0d", c, state_b, exp_st[c]); end
      if (c == 1) begin checks++; if (ctl_a !== e1) begin errors++; $display("FAIL alu_fetch1_ctl got %h exp %h", ctl_a, e1); end end
      if (c == 2) begin checks++; if (ctl_a !== e2) begin errors++; $display("FAIL alu_fetch2_ctl got %h exp %h", ctl_a, e2); end end
      if (c == 4) begin
        checks++; if (ctl_a !== e4) begin errors++; $display("FAIL alu_exec2_ctl got %h exp %h", ctl_a, e4); end
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL alu_instr_done got %b exp 1", done_a); end
      end
      if (c == 5) begin
        checks++; if (retired_a !== 16'd1) begin errors++; $display("FAIL alu_retired_a got %0d exp 1", retired_a); end
        checks++; if (retired_b !== 2'd1) begin errors++; $display("FAIL alu_retired_b got %0d exp 1", retired_b); end
      end
      tick();
    end
  endtask

  task automatic test_load_wait();
    int exp_st[9] = '{0, 1, 2, 3, 3, 3, 3, 4, 1};
    bit rdy[9]    = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
    ctl_t e3, e4;
    e3 = '0; e3.addr_sel = 1; e3.data_sel = 2'b01; e3.re = 1;
    e4 = '0; e4.addr_sel = 1; e4.data_sel = 2'b01; e4.reg_wrt = 1;
    apply_reset();
    opcode = 4'b1001; rega_data = 16'h0042;
    for (int c = 0; c < 9; c++) begin
      mem_rdy = rdy[c];
      @(negedge clk);
      checks++; if (state_a !== 3'(exp_st[c])) begin errors++; $display("FAIL lw_state_a c%0d got %0d exp %0d", c, state_a, exp_st[c]); end
      checks++; if (state_b !== 3'(exp_st[c])) begin errors++; $display("FAIL lw_state_b c%0d got %0d exp %0d", c, state_b, exp_st[c]); end
      if (exp_st[c] == 3) begin checks++; if (ctl_b !== e3) begin errors++; $display("FAIL lw_exec1_ctl c%0d got %h exp %h", c, ctl_b, e3); end end
      if (exp_st[c] == 4) begin checks++; if (ctl_a !== e4) begin errors++; $display("FAIL lw_exec2_ctl got %h exp %h", ctl_a, e4); end end
      tick();
    end
  endtask

  task automatic test_branches();
    int   ops[6]  = '{11, 11, 11, 12, 12, 12};
    int   vals[6] = '{0, 1, 32768, 0, 1, 32768};
    ctl_t e2, e4;
    apply_reset();
    mem_rdy = 1; halt_req = 0;
    @(negedge clk); tick();
    for (int i = 0; i < 6; i++) begin
      opcode = 4'(ops[i]); rega_data = 16'(vals[i]);
      e2 = '0; e2.pc_wrt = 1; e2.rega_sel = 1; e2.opa_sel = 1; e2.data_sel = 2'b10; e2.opb_sel = 2'b11;
      e4 = '0; e4.rega_sel = 1; e4.opa_sel = 1; e4.data_sel = 2'b01; e4.opb_sel = 2'b11;
      e4.pc_wrt = (ops[i] == 11) ? (vals[i] == 0) : (vals[i] != 0);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (c == 1) begin checks++; if (ctl_a !== e2) begin errors++; $display("FAIL br_fetch2_ctl op%0d got %h exp %h", ops[i], ctl_a, e2); end end
        if (c == 3) begin
          checks++; if (state_a !== 3'b100) begin errors++; $display("FAIL br_state op%0d got %0d exp 4", ops[i], state_a); end
          checks++; if (ctl_a !== e4) begin errors++; $display("FAIL br_exec2_ctl op%0d val %h got %h exp %h", ops[i], vals[i], ctl_a, e4); end
        end
        tick();
      end
    end
  endtask

  task automatic test_timeout();
    int ea, eb;
    apply_reset();
    opcode = 4'b0101; halt_req = 0;
    for (int c = 0; c < 22; c++) begin
      mem_rdy = (c >= 18); halt_req = (c >= 19);
      ea = (c == 0) ? 0 : (c <= 16) ? 1 : 6;
      eb = (c == 0) ? 0 : (c <= 4) ? 1 : 6;
      @(negedge clk);
      checks++; if (state_a !== 3'(ea)) begin errors++; $display("FAIL to_state_a c%0d got %0d exp %0d", c, state_a, ea); end
      checks++; if (state_b !== 3'(eb)) begin errors++; $display("FAIL to_state_b c%0d got %0d exp %0d", c, state_b, eb); end
      if (eb == 6) begin
        checks++; if (ctl_b !== '0 || err_b !== 1'b1) begin errors++; $display("FAIL to_err_b c%0d ctl %h bus_err %b exp 0 1", c, ctl_b, err_b); end
      end
      if (c >= 18) begin
        checks++; if (ctl_a !== '0 || err_a !== 1'b1) begin errors++; $display("FAIL to_err_a c%0d ctl %h bus_err %b exp 0 1", c, ctl_a, err_a); end
      end
      tick();
    end
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      mem_rdy = (c == 4);
      @(negedge clk);
      if (c == 5) begin
        checks++; if (state_b !== 3'b010 || err_b !== 1'b0) begin errors++; $display("FAIL to_rdy_wins state %0d bus_err %b exp 2 0", state_b, err_b); end
      end
      tick();
    end
  endtask

  task automatic test_halt();
    int exp_st[11] = '{0, 1, 2, 3, 4, 5, 5, 5, 1, 2, 3};
    ctl_t e;
    apply_reset();
    opcode = 4'b0000; rega_data = 16'd5;
    for (int c = 0; c < 11; c++) begin
      halt_req = (c >= 2 && c < 7);
      mem_rdy  = (c != 10);
      if (c == 8) opcode = 4'b1010;
      @(negedge clk);
      checks++; if (state_a !== 3'(exp_st[c])) begin errors++; $display("FAIL halt_state_a c%0d got %0d exp %0d", c, state_a, exp_st[c]); end
      if (exp_st[c] == 5) begin
        checks++; if (halted_b !== 1'b1 || ctl_b !== '0) begin errors++; $display("FAIL halt_out c%0d halted %b ctl %h exp 1 0", c, halted_b, ctl_b); end
      end
      if (c == 8) begin checks++; if (halted_a !== 1'b0) begin errors++; $display("FAIL halt_resume got %b exp 0", halted_a); end end
      if (c == 10) begin checks++; if (ifa.we !== 1'b1) begin errors++; $display("FAIL sw_we got %b exp 1", ifa.we); end end
      if (c < 10) tick();
    end
    reset_n = 0; #1;
    e = '0; e.pc_rst = 1;
    checks++; if (ctl_a !== e || state_a !== 3'b000) begin errors++; $display("FAIL sw_abort ctl %h state %0d exp %h 0", ctl_a, state_a, e); end
    checks++; if (ifb.we !== 1'b0 || state_b !== 3'b000) begin errors++; $display("FAIL sw_abort_b we %b state %0d exp 0 0", ifb.we, state_b); end
    tick(); reset_n = 1;
  endtask

  task automatic test_counter_wrap();
    int ndone = 0;
    apply_reset();
    opcode = 4'($urandom_range(0, 7)); mem_rdy = 1; halt_req = 0;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      if (done_a) ndone++;
      if (c == 21) begin
        checks++; if (ndone != 5) begin errors++; $display("FAIL wrap_done_count got %0d exp 5", ndone); end
        checks++; if (retired_a !== 16'd5) begin errors++; $display("FAIL wrap_retired_a got %0d exp 5", retired_a); end
        checks++; if (retired_b !== 2'd1) begin errors++; $display("FAIL wrap_retired_b got %0d exp 1", retired_b); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    int   pct;
    ctl_t ea, eb;
    apply_reset();
    for (int k = 0; k < 2; k++) begin m_st[k] = 0; m_nr[k] = 0; m_ret[k] = 0; end
    for (int n = 0; n < 3000; n++) begin
      case ((n / 250) % 3)
        0: pct = 95;
        1: pct = 60;
        default: pct = 8;
      endcase
      opcode    = 4'($urandom_range(0, 15));
      rega_data = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      mem_rdy   = ($urandom_range(0, 99) < pct);
      halt_req  = ($urandom_range(0, 9) == 0);
      reset_n   = ($urandom_range(0, 119) != 0);
      if (!reset_n) for (int k = 0; k < 2; k++) begin m_st[k] = 0; m_nr[k] = 0; m_ret[k] = 0; end
      @(negedge clk);
      ea = exp_ctl(m_st[0], int'(opcode), rega_data == 0, mem_rdy);
      eb = exp_ctl(m_st[1], int'(opcode), rega_data == 0, mem_rdy);
      checks++; if (state_a !== 3'(m_st[0])) begin errors++; $display("FAIL rnd_state_a n%0d got %0d exp %0d", n, state_a, m_st[0]); end
      checks++; if (state_b !== 3'(m_st[1])) begin errors++; $display("FAIL rnd_state_b n%0d got %0d exp %0d", n, state_b, m_st[1]); end
      checks++; if (ctl_a !== ea) begin errors++; $display("FAIL rnd_ctl_a n%0d op %h got %h exp %h", n, opcode, ctl_a, ea); end
      checks++; if (ctl_b !== eb) begin errors++; $display("FAIL rnd_ctl_b n%0d op %h got %h exp %h", n, opcode, ctl_b, eb); end
      checks++; if ({done_a, halted_a, err_a} !== {m_st[0] == 4, m_st[0] == 5, m_st[0] == 6}) begin errors++; $display("FAIL rnd_status_a n%0d got %b%b%b st %0d", n, done_a, halted_a, err_a, m_st[0]); end
      checks++; if ({done_b, halted_b, err_b} !== {m_st[1] == 4, m_st[1] == 5, m_st[1] == 6}) begin errors++; $display("FAIL rnd_status_b n%0d got %b%b%b st %0d", n, done_b, halted_b, err_b, m_st[1]); end
      checks++; if (retired_a !== 16'(m_ret[0] % (1 << CW_A))) begin errors++; $display("FAIL rnd_retired_a n%0d got %0d exp %0d", n, retired_a, m_ret[0] % (1 << CW_A)); end
      checks++; if (retired_b !== 2'(m_ret[1] % (1 << CW_B))) begin errors++; $display("FAIL rnd_retired_b n%0d got %0d exp %0d", n, retired_b, m_ret[1] % (1 << CW_B)); end
      @(posedge clk);
      model_step(0, TO_A);
      model_step(1, TO_B);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_branches();
    test_timeout();
    test_halt();
    test_counter_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
